hidden_cpu_program_feeder: RTL and testbench

- Upstream instruction source for the 6-bit-instruction CPU core, which takes opcode/address bits on io_in[7:2] and executes one instruction per clock.
- Accepts a program over a valid/ready load port and stores it in a small on-chip instruction memory.
- Holds the CPU in reset while loading, then streams the stored instructions to the core, one per clock, with optional looping and stall.

---
 rtl/hidden_cpu_program_feeder_if.sv | 28 ++
 rtl/hidden_cpu_program_feeder.sv | 148 ++++++++++++++
 tb/tb_hidden_cpu_program_feeder.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hidden_cpu_program_feeder_if.sv
// Load/stream bundle between the program source, the feeder and the CPU core.
// Master drives the load and stall controls; the feeder (slave) returns the core-facing outputs.
interface hidden_cpu_program_feeder_if #(
  parameter int ADDR_W = 4
);
  logic              load_start;
  logic              load_valid;
  logic [5:0]        load_data;
  logic              load_ready;
  logic              load_end;
  logic              stall;
  logic [5:0]        instr_out;
  logic              cpu_rst;
  logic [ADDR_W:0]   prog_len;
  logic              running;
  logic              halted;
  logic              empty_err;

  modport master (
    output load_start, load_valid, load_data, load_end, stall,
    input  load_ready, instr_out, cpu_rst, prog_len, running, halted, empty_err
  );

  modport slave (
    input  load_start, load_valid, load_data, load_end, stall,
    output load_ready, instr_out, cpu_rst, prog_len, running, halted, empty_err
  );
endinterface

// File: rtl/hidden_cpu_program_feeder.sv
// Loads a program into a small instruction memory, holds the core in reset, then issues one instruction
// per clock straight from the registered read pointer (0 latency); stall inserts NOPs, load_ready gates writes.
module hidden_cpu_program_feeder #(
  parameter int         DEPTH      = 16,
  parameter int         ADDR_W     = 4,
  parameter int         RST_CYCLES = 2,
  parameter int         LOOP       = 1,
  parameter logic [5:0] NOP_INSTR  = 6'b000000
) (
  input  logic                          clk,
  input  logic                          rst,
  hidden_cpu_program_feeder_if.slave    bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CPURST,
    S_RUN,
    S_HALT
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W+1)'(DEPTH);
  localparam logic [3:0]      RST_LAST = 4'(RST_CYCLES - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] wr_ptr, wr_ptr_nxt;
  logic [ADDR_W-1:0] rd_ptr, rd_ptr_nxt;
  logic [ADDR_W:0]   prog_len, prog_len_nxt;
  logic [3:0]        rst_cnt, rst_cnt_nxt;
  logic              empty_err, empty_err_nxt;
  logic              wr_en;
  logic [ADDR_W:0]   len_w;

  logic [5:0] mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      prog_len  <= '0;
      rst_cnt   <= '0;
      empty_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      wr_ptr    <= wr_ptr_nxt;
      rd_ptr    <= rd_ptr_nxt;
      prog_len  <= prog_len_nxt;
      rst_cnt   <= rst_cnt_nxt;
      empty_err <= empty_err_nxt;
    end
  end

  // Program storage is deliberately left unreset; prog_len qualifies its contents.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= bus.load_data;
    end
  end

  always_comb begin
    state_nxt     = state;
    wr_ptr_nxt    = wr_ptr;
    rd_ptr_nxt    = rd_ptr;
    prog_len_nxt  = prog_len;
    rst_cnt_nxt   = rst_cnt;
    empty_err_nxt = empty_err;
    wr_en         = 1'b0;
    len_w         = prog_len;

    bus.load_ready = 1'b0;
    bus.cpu_rst    = 1'b1;
    bus.running    = 1'b0;
    bus.halted     = 1'b0;
    bus.instr_out  = NOP_INSTR;

    unique case (state)
      S_LOAD: bus.load_ready = (prog_len < DEPTH_L);
      S_RUN: begin
        bus.cpu_rst = 1'b0;
        bus.running = 1'b1;
        if (!bus.stall) begin
          bus.instr_out = mem[rd_ptr];
        end
      end
      S_HALT: begin
        bus.cpu_rst = 1'b0;
        bus.halted  = 1'b1;
      end
      default: ;
    endcase

    // load_start restarts from any state and overrides every other control this cycle.
    if (bus.load_start) begin
      state_nxt     = S_LOAD;
      wr_ptr_nxt    = '0;
      rd_ptr_nxt    = '0;
      prog_len_nxt  = '0;
      rst_cnt_nxt   = '0;
      empty_err_nxt = 1'b0;
    end else begin
      unique case (state)
        S_LOAD: begin
          wr_en = bus.load_valid && bus.load_ready;
          len_w = prog_len + {{ADDR_W{1'b0}}, wr_en};
          if (wr_en) begin
            wr_ptr_nxt   = wr_ptr + 1'b1;
            prog_len_nxt = len_w;
          end
          if (bus.load_end) begin
            if (len_w != '0) begin
              state_nxt   = S_CPURST;
              rst_cnt_nxt = '0;
            end else begin
              state_nxt     = S_IDLE;
              empty_err_nxt = 1'b1;
            end
          end
        end
        S_CPURST: begin
          rst_cnt_nxt = rst_cnt + 1'b1;
          if (rst_cnt == RST_LAST) begin
            state_nxt  = S_RUN;
            rd_ptr_nxt = '0;
          end
        end
        S_RUN: begin
          if (!bus.stall) begin
            if ({1'b0, rd_ptr} == prog_len - 1'b1) begin
              rd_ptr_nxt = '0;
              if (LOOP == 0) begin
                state_nxt = S_HALT;
              end
            end else begin
              rd_ptr_nxt = rd_ptr + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.prog_len  = prog_len;
  assign bus.empty_err = empty_err;

endmodule

// File: tb/tb_hidden_cpu_program_feeder.sv
// Scoreboard bench: expected instructions are queued as programs are loaded and popped on each RUN cycle.
module tb_hidden_cpu_program_feeder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [5:0] words [$];
  logic [5:0] exp_q [$];
  logic [6:0] exp_b_q [$];

  always #5 clk = ~clk;

  hidden_cpu_program_feeder_if #(.ADDR_W(4)) if_a ();
  hidden_cpu_program_feeder_if #(.ADDR_W(4)) if_b ();

  hidden_cpu_program_feeder #(.DEPTH(16), .ADDR_W(4), .RST_CYCLES(2), .LOOP(1), .NOP_INSTR(6'b000000))
    dut_a (.clk(clk), .rst(rst), .bus(if_a));

  hidden_cpu_program_feeder #(.DEPTH(16), .ADDR_W(4), .RST_CYCLES(2), .LOOP(0), .NOP_INSTR(6'b000000))
    dut_b (.clk(clk), .rst(rst), .bus(if_b));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_a(input bit end_with_last);
    if_a.load_start = 1'b1;
    step();
    if_a.load_start = 1'b0;
    foreach (words[i]) begin
      if_a.load_valid = 1'b1;
      if_a.load_data  = words[i];
      if_a.load_end   = end_with_last && (i == words.size() - 1);
      step();
    end
    if_a.load_valid = 1'b0;
    if_a.load_end   = 1'b0;
    if (!end_with_last || words.size() == 0) begin
      if_a.load_end = 1'b1;
      step();
      if_a.load_end = 1'b0;
    end
  endtask

  // Pops one expected word per RUN cycle; stall_pat bit k stalls the k-th RUN cycle.
  task automatic drain_a(input string name, input logic [31:0] stall_pat, input int budget);
    int k = 0;
    int b = 0;
    logic [5:0] exp;
    while (exp_q.size() > 0 && b < budget) begin
      if_a.stall = if_a.running && (k < 32) ? stall_pat[k] : 1'b0;
      @(negedge clk);
      if (if_a.running) begin
        exp = exp_q.pop_front();
        checks++;
        if (if_a.instr_out !== exp) begin
          errors++;
          $display("FAIL %s instr_out[%0d]: got %h, expected %h", name, k, if_a.instr_out, exp);
        end
        k++;
      end
      step();
      b++;
    end
    if_a.stall = 1'b0;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: %0d expected words not issued", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({if_a.cpu_rst, if_a.instr_out, if_a.load_ready, if_a.running, if_a.halted, if_a.prog_len, if_a.empty_err}
        !== {1'b1, 6'h00, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset: cpu_rst=%b instr=%h ready=%b run=%b halt=%b len=%0d err=%b, expected 1 00 0 0 0 0 0",
               if_a.cpu_rst, if_a.instr_out, if_a.load_ready, if_a.running, if_a.halted, if_a.prog_len, if_a.empty_err);
    end
    #9 rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    words = '{6'h05, 6'h2A, 6'h3F};
    load_a(1'b0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (if_a.cpu_rst !== 1'b1 || if_a.running !== 1'b0) begin
        errors++;
        $display("FAIL basic cpurst cycle %0d: cpu_rst=%b running=%b, expected 1 0", c, if_a.cpu_rst, if_a.running);
      end
      step();
    end
    @(negedge clk);
    checks++;
    if (if_a.cpu_rst !== 1'b0 || if_a.running !== 1'b1 || if_a.prog_len !== 5'd3) begin
      errors++;
      $display("FAIL basic run entry: cpu_rst=%b running=%b prog_len=%0d, expected 0 1 3",
               if_a.cpu_rst, if_a.running, if_a.prog_len);
    end
    step();
    exp_q = '{6'h2A, 6'h3F, 6'h05, 6'h2A, 6'h3F, 6'h05};
    drain_a("basic", 32'h0, 20);
  endtask

  task automatic test_full();
    if_a.load_start = 1'b1;
    step();
    if_a.load_start = 1'b0;
    for (int i = 0; i < 17; i++) begin
      if_a.load_valid = 1'b1;
      if_a.load_data  = 6'(i * 3 + 1);
      @(negedge clk);
      checks++;
      if (if_a.load_ready !== (i < 16)) begin
        errors++;
        $display("FAIL full load_ready word %0d: got %b, expected %b", i, if_a.load_ready, (i < 16));
      end
      step();
    end
    if_a.load_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (if_a.prog_len !== 5'd16) begin
      errors++;
      $display("FAIL full prog_len: got %0d, expected 16", if_a.prog_len);
    end
    step();
    if_a.load_end = 1'b1;
    step();
    if_a.load_end = 1'b0;
    for (int i = 0; i < 16; i++) exp_q.push_back(6'(i * 3 + 1));
    exp_q.push_back(6'h01);
    exp_q.push_back(6'h04);
    drain_a("full", 32'h0, 40);
  endtask

  task automatic test_halt();
    int b = 0;
    logic [6:0] exp;
    if_b.load_start = 1'b1;
    step();
    if_b.load_start = 1'b0;
    if_b.load_valid = 1'b1;
    if_b.load_data  = 6'h11;
    step();
    if_b.load_data  = 6'h22;
    step();
    if_b.load_valid = 1'b0;
    if_b.load_end   = 1'b1;
    step();
    if_b.load_end   = 1'b0;
    exp_b_q = '{{1'b0, 6'h11}, {1'b0, 6'h22}, {1'b1, 6'h00}, {1'b1, 6'h00}, {1'b1, 6'h00}};
    while (exp_b_q.size() > 0 && b < 15) begin
      @(negedge clk);
      if (if_b.running || if_b.halted) begin
        exp = exp_b_q.pop_front();
        checks++;
        if ({if_b.halted, if_b.instr_out} !== exp || if_b.cpu_rst !== 1'b0) begin
          errors++;
          $display("FAIL halt seq: halted=%b instr=%h cpu_rst=%b, expected halted=%b instr=%h cpu_rst=0",
                   if_b.halted, if_b.instr_out, if_b.cpu_rst, exp[6], exp[5:0]);
        end
      end
      step();
      b++;
    end
    if (exp_b_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL halt timeout: %0d entries outstanding", exp_b_q.size());
      exp_b_q.delete();
    end
  endtask

  task automatic test_stall();
    words = '{6'h01, 6'h02, 6'h03};
    load_a(1'b1);
    @(negedge clk);
    checks++;
    if (if_a.prog_len !== 5'd3 || if_a.cpu_rst !== 1'b1) begin
      errors++;
      $display("FAIL stall end-with-write: prog_len=%0d cpu_rst=%b, expected 3 1", if_a.prog_len, if_a.cpu_rst);
    end
    step();
    exp_q = '{6'h01, 6'h00, 6'h00, 6'h02, 6'h03, 6'h01};
    drain_a("stall", 32'h6, 20);
  endtask

  task automatic test_empty();
    words.delete();
    load_a(1'b0);
    @(negedge clk);
    checks++;
    if (if_a.empty_err !== 1'b1 || if_a.cpu_rst !== 1'b1 || if_a.load_ready !== 1'b0 || if_a.running !== 1'b0) begin
      errors++;
      $display("FAIL empty: err=%b cpu_rst=%b ready=%b running=%b, expected 1 1 0 0",
               if_a.empty_err, if_a.cpu_rst, if_a.load_ready, if_a.running);
    end
    step();
    if_a.load_start = 1'b1;
    step();
    if_a.load_start = 1'b0;
    @(negedge clk);
    checks++;
    if (if_a.empty_err !== 1'b0 || if_a.load_ready !== 1'b1) begin
      errors++;
      $display("FAIL empty clear: err=%b ready=%b, expected 0 1", if_a.empty_err, if_a.load_ready);
    end
    step();
  endtask

  task automatic test_abort();
    words = '{6'h0A, 6'h0B, 6'h0C};
    load_a(1'b0);
    exp_q = '{6'h0A, 6'h0B};
    drain_a("abort pre", 32'h0, 10);
    if_a.load_start = 1'b1;
    @(negedge clk);
    checks++;
    if (if_a.cpu_rst !== 1'b0 || if_a.instr_out !== 6'h0C) begin
      errors++;
      $display("FAIL abort same cycle: cpu_rst=%b instr=%h, expected 0 0c", if_a.cpu_rst, if_a.instr_out);
    end
    step();
    if_a.load_start = 1'b0;
    @(negedge clk);
    checks++;
    if (if_a.cpu_rst !== 1'b1 || if_a.prog_len !== 5'd0 || if_a.instr_out !== 6'h00 || if_a.running !== 1'b0) begin
      errors++;
      $display("FAIL abort next: cpu_rst=%b len=%0d instr=%h running=%b, expected 1 0 00 0",
               if_a.cpu_rst, if_a.prog_len, if_a.instr_out, if_a.running);
    end
    step();
    words = '{6'h07};
    load_a(1'b0);
    @(negedge clk);
    checks++;
    if (if_a.instr_out !== 6'h00 || if_a.cpu_rst !== 1'b1) begin
      errors++;
      $display("FAIL abort cpurst: instr=%h cpu_rst=%b, expected 00 1", if_a.instr_out, if_a.cpu_rst);
    end
    step();
    exp_q = '{6'h07, 6'h07, 6'h07, 6'h07};
    drain_a("single loop", 32'h0, 12);
  endtask

  task automatic test_rst_mid();
    words = '{6'h09, 6'h0D};
    load_a(1'b0);
    rst = 1'b1;
    #1;
    checks++;
    if (if_a.cpu_rst !== 1'b1 || if_a.prog_len !== 5'd0 || if_a.running !== 1'b0 || if_a.instr_out !== 6'h00) begin
      errors++;
      $display("FAIL rst mid-cpurst: cpu_rst=%b len=%0d running=%b instr=%h, expected 1 0 0 00",
               if_a.cpu_rst, if_a.prog_len, if_a.running, if_a.instr_out);
    end
    #1 rst = 1'b0;
    step();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (if_a.running !== 1'b0 || if_a.cpu_rst !== 1'b1 || if_a.instr_out !== 6'h00) begin
        errors++;
        $display("FAIL rst idle cycle %0d: running=%b cpu_rst=%b instr=%h, expected 0 1 00",
                 c, if_a.running, if_a.cpu_rst, if_a.instr_out);
      end
      step();
    end
  endtask

  initial begin
    if_a.load_start = 1'b0; if_a.load_valid = 1'b0; if_a.load_data = 6'h00; if_a.load_end = 1'b0; if_a.stall = 1'b0;
    if_b.load_start = 1'b0; if_b.load_valid = 1'b0; if_b.load_data = 6'h00; if_b.load_end = 1'b0; if_b.stall = 1'b0;
    test_reset();
    test_basic();
    test_full();
    test_halt();
    test_stall();
    test_empty();
    test_abort();
    test_rst_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
